// File: rtl/lcd_pkg.sv
// Shared types and command constants for the HD44780-style 4-bit line driver.
package lcd_pkg;

    typedef enum logic [2:0] {
        PWRUP,
        INIT,
        ADDR1,
        LINE1,
        ADDR2,
        LINE2
    } lcd_state_t;

    typedef enum logic [1:0] {
        PH_IDLE,
        PH_HI,
        PH_LO,
        PH_WAIT
    } lcd_phase_t;

    // single = 1: only code[3:0] is sent, as one nibble
    typedef struct packed {
        logic       rs;
        logic       single;
        logic [7:0] code;
    } lcd_item_t;

    localparam logic [7:0] CMD_FUNC_SET = 8'h28;
    localparam logic [7:0] CMD_DISP_ON  = 8'h0C;
    localparam logic [7:0] CMD_ENTRY    = 8'h06;
    localparam logic [7:0] CMD_CLEAR    = 8'h01;
    localparam logic [7:0] CMD_LINE1    = 8'h80;
    localparam logic [7:0] CMD_LINE2    = 8'hC0;
    localparam logic [7:0] ASCII_SPACE  = 8'h20;

    function automatic lcd_item_t init_item(input logic [2:0] idx);
        lcd_item_t it;
        case (idx)
            3'd0, 3'd1, 3'd2: it = '{rs: 1'b0, single: 1'b1, code: 8'h03};
            3'd3:             it = '{rs: 1'b0, single: 1'b1, code: 8'h02};
            3'd4:             it = '{rs: 1'b0, single: 1'b0, code: CMD_FUNC_SET};
            3'd5:             it = '{rs: 1'b0, single: 1'b0, code: CMD_DISP_ON};
            3'd6:             it = '{rs: 1'b0, single: 1'b0, code: CMD_ENTRY};
            default:          it = '{rs: 1'b0, single: 1'b0, code: CMD_CLEAR};
        endcase
        return it;
    endfunction

endpackage

// File: rtl/lcd_nibble_tx.sv
// One 4-bit bus transaction: setup cycle, lcd_e high pulse, lcd_e low gap.
module lcd_nibble_tx #(
    parameter int unsigned E_HIGH_CYCLES     = 12,
    parameter int unsigned NIBBLE_GAP_CYCLES = 50
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       rs,
    input  logic [3:0] nibble,
    output logic       busy,
    output logic       done,
    output logic       lcd_e,
    output logic       lcd_rs,
    output logic [3:0] lcd_data
);

    localparam int unsigned LAST = E_HIGH_CYCLES + NIBBLE_GAP_CYCLES;
    localparam int unsigned CW   = $clog2(LAST + 1);

    logic [CW-1:0] cnt;

    // done marks the final gap cycle so the next nibble can start back-to-back
    assign done = busy && (cnt == CW'(LAST));

    always_ff @(posedge clk) begin
        if (rst) begin
            busy     <= 1'b0;
            cnt      <= '0;
            lcd_e    <= 1'b0;
            lcd_rs   <= 1'b0;
            lcd_data <= '0;
        end else if (start && (!busy || done)) begin
            busy     <= 1'b1;
            cnt      <= '0;
            lcd_e    <= 1'b0;
            lcd_rs   <= rs;
            lcd_data <= nibble;
        end else if (busy) begin
            if (done) begin
                busy  <= 1'b0;
                cnt   <= '0;
                lcd_e <= 1'b0;
            end else begin
                cnt   <= cnt + 1'b1;
                lcd_e <= (cnt < CW'(E_HIGH_CYCLES));
            end
        end
    end

endmodule

// File: rtl/lcd_line_driver.sv
// Two-line character LCD refresher over a 4-bit bus.
// Build option: LCD_NULL_AS_SPACE_EN sends 0x00 data bytes as spaces.
module lcd_line_driver #(
    parameter int unsigned POWERUP_CYCLES    = 750000,
    parameter int unsigned E_HIGH_CYCLES     = 12,
    parameter int unsigned NIBBLE_GAP_CYCLES = 50,
    parameter int unsigned CMD_WAIT_CYCLES   = 2000,
    parameter int unsigned CLEAR_WAIT_CYCLES = 82000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [0:127] first_line_data,
    input  logic [0:127] second_line_data,
    output logic         lcd_rs,
    output logic         lcd_rw,
    output logic         lcd_e,
    output logic         lcd4,
    output logic         lcd5,
    output logic         lcd6,
    output logic         lcd7,
    output logic         init_done,
    output logic         frame_done
);

    import lcd_pkg::*;

    lcd_state_t   state, nxt_state;
    lcd_phase_t   phase;
    logic [2:0]   init_idx, nxt_idx;
    logic [3:0]   char_idx, nxt_char;
    logic [31:0]  cnt, wait_len;
    logic [0:127] snap1, snap2;
    lcd_item_t    cur_item, nxt_item;
    logic         launch, tx_start, tx_rs, tx_busy, tx_done;
    logic [3:0]   tx_nib, lcd_data;

    function automatic lcd_item_t data_item(input logic [0:127] line, input logic [3:0] k);
        logic [7:0] b;
        b = line[{k, 3'b000} +: 8];
`ifdef LCD_NULL_AS_SPACE_EN
        if (b == 8'h00) b = ASCII_SPACE;
`endif
        return '{rs: 1'b1, single: 1'b0, code: b};
    endfunction

    function automatic lcd_item_t item_at(input lcd_state_t st, input logic [2:0] idx,
                                          input logic [3:0] ch, input logic [0:127] l1,
                                          input logic [0:127] l2);
        lcd_item_t it;
        case (st)
            INIT:    it = init_item(idx);
            ADDR1:   it = '{rs: 1'b0, single: 1'b0, code: CMD_LINE1};
            LINE1:   it = data_item(l1, ch);
            ADDR2:   it = '{rs: 1'b0, single: 1'b0, code: CMD_LINE2};
            LINE2:   it = data_item(l2, ch);
            default: it = '0;
        endcase
        return it;
    endfunction

    always_comb begin
        nxt_state = state;
        nxt_idx   = init_idx;
        nxt_char  = char_idx;
        case (state)
            PWRUP: begin
                nxt_state = INIT;
                nxt_idx   = '0;
            end
            INIT: begin
                if (init_idx == 3'd7) begin
                    nxt_state = ADDR1;
                    nxt_idx   = '0;
                end else begin
                    nxt_idx = init_idx + 3'd1;
                end
            end
            ADDR1: begin
                nxt_state = LINE1;
                nxt_char  = '0;
            end
            LINE1: begin
                nxt_char = char_idx + 4'd1;
                if (char_idx == 4'd15) nxt_state = ADDR2;
            end
            ADDR2: begin
                nxt_state = LINE2;
                nxt_char  = '0;
            end
            LINE2: begin
                nxt_char = char_idx + 4'd1;
                if (char_idx == 4'd15) nxt_state = ADDR1;
            end
            default: nxt_state = PWRUP;
        endcase
    end

    // The next item's first nibble is launched in the last wait cycle, using the
    // look-ahead pointer, so the state advances exactly when the wait ends.
    always_comb begin
        cur_item = item_at(state, init_idx, char_idx, snap1, snap2);
        nxt_item = item_at(nxt_state, nxt_idx, nxt_char, snap1, snap2);
        wait_len = (!cur_item.rs && !cur_item.single && cur_item.code == CMD_CLEAR)
                   ? 32'(CLEAR_WAIT_CYCLES) : 32'(CMD_WAIT_CYCLES);
        launch   = !tx_busy &&
                   ((phase == PH_IDLE && cnt == 32'(POWERUP_CYCLES - 1)) ||
                    (phase == PH_WAIT && cnt == wait_len - 32'd1));
        tx_start = launch || (phase == PH_HI && tx_done && !cur_item.single);
        tx_rs    = launch ? nxt_item.rs : cur_item.rs;
        if (launch)
            tx_nib = nxt_item.single ? nxt_item.code[3:0] : nxt_item.code[7:4];
        else
            tx_nib = cur_item.code[3:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= PWRUP;
            phase      <= PH_IDLE;
            cnt        <= '0;
            init_idx   <= '0;
            char_idx   <= '0;
            snap1      <= '0;
            snap2      <= '0;
            init_done  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (launch) begin
                state    <= nxt_state;
                init_idx <= nxt_idx;
                char_idx <= nxt_char;
                phase    <= PH_HI;
                cnt      <= '0;
                if (nxt_state == ADDR1) begin
                    snap1     <= first_line_data;
                    snap2     <= second_line_data;
                    init_done <= 1'b1;
                    if (state == LINE2) frame_done <= 1'b1;
                end
            end else begin
                case (phase)
                    PH_IDLE: cnt <= cnt + 32'd1;
                    PH_HI:   if (tx_done) phase <= cur_item.single ? PH_WAIT : PH_LO;
                    PH_LO:   if (tx_done) phase <= PH_WAIT;
                    PH_WAIT: cnt <= cnt + 32'd1;
                    default: phase <= PH_IDLE;
                endcase
            end
        end
    end

    lcd_nibble_tx #(
        .E_HIGH_CYCLES    (E_HIGH_CYCLES),
        .NIBBLE_GAP_CYCLES(NIBBLE_GAP_CYCLES)
    ) u_tx (
        .clk     (clk),
        .rst     (rst),
        .start   (tx_start),
        .rs      (tx_rs),
        .nibble  (tx_nib),
        .busy    (tx_busy),
        .done    (tx_done),
        .lcd_e   (lcd_e),
        .lcd_rs  (lcd_rs),
        .lcd_data(lcd_data)
    );

    assign lcd_rw = 1'b0;
    assign lcd4   = lcd_data[0];
    assign lcd5   = lcd_data[1];
    assign lcd6   = lcd_data[2];
    assign lcd7   = lcd_data[3];

endmodule

// File: tb/tb_lcd_line_driver.sv
// Directed bench for lcd_line_driver with shortened timing parameters.
module tb_lcd_line_driver;

    logic         clk = 1'b0;
    logic         rst;
    logic [0:127] line1, line2;
    logic         lcd_rs, lcd_rw, lcd_e, lcd4, lcd5, lcd6, lcd7, init_done, frame_done;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int fd_cnt = 0;
    int hi_len = 0;
    logic prev_e = 1'b0;

    logic [4:0] nib_q[$];
    int         rise_q[$];
    logic       init_q[$];
    int         width_q[$];

    logic [4:0] exp_init [12] = '{5'h03, 5'h03, 5'h03, 5'h02, 5'h02, 5'h08,
                                  5'h00, 5'h0C, 5'h00, 5'h06, 5'h00, 5'h01};
    logic [7:0] exp_l1 [16];

    lcd_line_driver #(
        .POWERUP_CYCLES   (20),
        .E_HIGH_CYCLES    (2),
        .NIBBLE_GAP_CYCLES(3),
        .CMD_WAIT_CYCLES  (4),
        .CLEAR_WAIT_CYCLES(10)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .first_line_data (line1),
        .second_line_data(line2),
        .lcd_rs          (lcd_rs),
        .lcd_rw          (lcd_rw),
        .lcd_e           (lcd_e),
        .lcd4            (lcd4),
        .lcd5            (lcd5),
        .lcd6            (lcd6),
        .lcd7            (lcd7),
        .init_done       (init_done),
        .frame_done      (frame_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Bus monitor: records every nibble at its lcd_e rise, plus pulse widths.
    always @(negedge clk) begin
        if (lcd_e && !prev_e) begin
            nib_q.push_back({lcd_rs, lcd7, lcd6, lcd5, lcd4});
            rise_q.push_back(cyc);
            init_q.push_back(init_done);
        end
        if (lcd_e) hi_len++;
        else if (prev_e) begin
            width_q.push_back(hi_len);
            hi_len = 0;
        end
        if (frame_done) fd_cnt++;
        prev_e = lcd_e;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_nibs(input int target, input int budget);
        int n = 0;
        while (nib_q.size() < target && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk($sformatf("nibble_count_%0d", target), 32'(nib_q.size() >= target), 32'd1);
    endtask

    task automatic count_rise(output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!lcd_e && n < 100);
    endtask

    task automatic check_byte(input string tag, input int i, input logic rs, input logic [7:0] b);
        logic [9:0] obs;
        obs = {nib_q[i][4], nib_q[i+1][4], nib_q[i][3:0], nib_q[i+1][3:0]};
        chk(tag, 32'(obs), 32'({rs, rs, b}));
    endtask

    task automatic check_frame(input int base, input logic [7:0] l2_first);
        check_byte("addr1_cmd", base, 1'b0, 8'h80);
        for (int k = 0; k < 16; k++)
            check_byte($sformatf("line1_k%0d", k), base + 2 + 2 * k, 1'b1, exp_l1[k]);
        check_byte("addr2_cmd", base + 34, 1'b0, 8'hC0);
        for (int k = 0; k < 16; k++)
            check_byte($sformatf("line2_k%0d", k), base + 36 + 2 * k, 1'b1, l2_first + 8'(k));
    endtask

    initial begin
        int n;
        int base;
        logic [7:0] pad;
`ifdef LCD_NULL_AS_SPACE_EN
        pad = 8'h20;
`else
        pad = 8'h00;
`endif
        exp_l1 = '{8'h30, 8'h2C, 8'h20, 8'h31, 8'h2C, 8'h20, 8'h32, 8'h2C,
                   8'h20, 8'h33, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        for (int k = 10; k < 16; k++) exp_l1[k] = pad;

        rst   = 1'b1;
        line1 = {"0, 1, 2, 3", 48'h0};
        line2 = "ABCDEFGHIJKLMNOP";
        repeat (3) @(posedge clk);
        #1;
        chk("rst_lcd_e", 32'(lcd_e), 32'd0);
        chk("rst_lcd_rs", 32'(lcd_rs), 32'd0);
        chk("rst_lcd_rw", 32'(lcd_rw), 32'd0);
        chk("rst_data", 32'({lcd7, lcd6, lcd5, lcd4}), 32'd0);
        chk("rst_init_done", 32'(init_done), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);

        @(negedge clk);
        rst = 1'b0;
        count_rise(n);
        chk("pwrup_to_first_e", 32'(n), 32'd21);
        chk("first_nibble", 32'({lcd_rs, lcd7, lcd6, lcd5, lcd4}), 32'h03);

        wait_nibs(13, 400);
        for (int i = 0; i < 12; i++)
            chk($sformatf("init_nib_%0d", i), 32'(nib_q[i]), 32'(exp_init[i]));
        chk("e_high_width", 32'(width_q[0]), 32'd2);
        chk("init_single_spacing", 32'(rise_q[1] - rise_q[0]), 32'd10);
        chk("init_nibble_spacing", 32'(rise_q[5] - rise_q[4]), 32'd6);
        chk("clear_wait_spacing", 32'(rise_q[12] - rise_q[11]), 32'd16);
        chk("init_done_before_addr1", 32'(init_q[11]), 32'd0);
        chk("init_done_at_addr1", 32'(init_q[12]), 32'd1);
        chk("no_frame_done_after_init", 32'(fd_cnt), 32'd0);

        wait_nibs(24, 800);
        line2 = "abcdefghijklmnop";

        wait_nibs(81, 2000);
        check_frame(12, 8'h41);
        chk("byte_wait_spacing", 32'(rise_q[16] - rise_q[15]), 32'd10);
        chk("frame_done_frame1", 32'(fd_cnt), 32'd1);

        wait_nibs(149, 2000);
        check_frame(80, 8'h61);
        chk("frame_done_frame2", 32'(fd_cnt), 32'd2);

        wait_nibs(199, 1000);
        chk("line2_k7_hi_nibble", 32'(nib_q[198]), 32'h16);
        chk("mid_nibble_e_high", 32'(lcd_e), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_lcd_e", 32'(lcd_e), 32'd0);
        chk("midrst_init_done", 32'(init_done), 32'd0);
        chk("midrst_lcd_rs", 32'(lcd_rs), 32'd0);
        chk("midrst_frame_done", 32'(frame_done), 32'd0);

        @(negedge clk);
        rst  = 1'b0;
        base = nib_q.size();
        count_rise(n);
        chk("replay_pwrup_to_first_e", 32'(n), 32'd21);
        wait_nibs(base + 14, 600);
        for (int i = 0; i < 12; i++)
            chk($sformatf("replay_init_nib_%0d", i), 32'(nib_q[base + i]), 32'(exp_init[i]));
        check_byte("replay_addr1_cmd", base + 12, 1'b0, 8'h80);
        chk("replay_no_frame_done", 32'(fd_cnt), 32'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lcd_line_driver.md
LCD_LINE_DRIVER -- requirements
Module: lcd_line_driver

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- POWERUP_CYCLES, 750000, clocks of idle wait after reset before the first init nibble.
- E_HIGH_CYCLES, 12, clocks lcd_e is held high per nibble.
- NIBBLE_GAP_CYCLES, 50, clocks lcd_e is held low after each nibble.
- CMD_WAIT_CYCLES, 2000, extra clocks after every byte except clear.
- CLEAR_WAIT_CYCLES, 82000, extra clocks after the clear-display command.
REQ-002 Ports (name, direction, width, meaning), one per line:
- clk, in, 1, sole clock, rising edge.
- rst, in, 1, synchronous, active-high reset.
- first_line_data, in, [0:127], 16 ASCII bytes; byte k = bits [8k:8k+7], k=0 leftmost.
- second_line_data, in, [0:127], same layout, for line 2.
- lcd_rs, out, 1, 0 = command, 1 = data.
- lcd_rw, out, 1, constant 0 (write only).
- lcd_e, out, 1, enable strobe.
- lcd4, lcd5, lcd6, lcd7, out, 1 each, nibble bits 0..3.
- init_done, out, 1, high once the init sequence completes; stays high until reset.
- frame_done, out, 1, one-cycle pulse after the last character of line 2 is written.

Function
REQ-003 The FSM SHALL use these states: PWRUP, INIT, ADDR1, LINE1, ADDR2, LINE2, in that order, with LINE2 returning to ADDR1 forever.
REQ-004 PWRUP SHALL idle exactly POWERUP_CYCLES clocks with lcd_e=0.
REQ-005 INIT SHALL send these items in order:
- rs=0 single nibbles 0x3, 0x3, 0x3, 0x2;
- then rs=0 bytes 0x28, 0x0C, 0x06, 0x01.
REQ-006 Each nibble transaction SHALL follow this timing:
- lcd_rs and lcd4..7 become valid in cycle 0 with lcd_e=0;
- lcd_e=1 for cycles 1..E_HIGH_CYCLES;
- lcd_e=0 for the next NIBBLE_GAP_CYCLES;
- rs and data are held stable throughout.
REQ-007 A byte SHALL be sent as the high nibble then the low nibble, followed by CMD_WAIT_CYCLES, or CLEAR_WAIT_CYCLES for 0x01.
REQ-008 ADDR1 SHALL send command 0x80; ADDR2 SHALL send command 0xC0.
REQ-009 LINE1 and LINE2 SHALL send 16 data bytes (rs=1), k=0..15, from the frame snapshot.
REQ-010 Both 128-bit inputs SHALL be captured into a snapshot register in the cycle ADDR1 is entered; input changes during a frame SHALL NOT affect that frame.
REQ-011 The character index SHALL be 4 bits and wrap 15->0 on line change; no 17th byte is ever sent.
REQ-012 init_done SHALL rise in the cycle ADDR1 is first entered.
REQ-013 frame_done SHALL pulse for 1 cycle when the LINE2 k=15 byte wait ends, coincident with re-entry to ADDR1.
REQ-014 All outputs SHALL be registered; there are no combinational paths from inputs to outputs.

Reset
REQ-015 rst SHALL have priority over all other logic at any clock edge, including mid-nibble and mid-wait.
REQ-016 Reset values SHALL be: state PWRUP, all counters 0, lcd_e=0, lcd_rs=0, lcd_rw=0, lcd4..7=0, init_done=0, frame_done=0, snapshot=0.
REQ-017 Reset asserted mid-operation SHALL restart the full POWERUP and INIT sequence.

Configuration
REQ-018 When the macro LCD_NULL_AS_SPACE_EN is defined, data bytes equal to 0x00 SHALL be sent as 0x20; when it is undefined, bytes SHALL be sent unmodified. Commands are never substituted.

Structure
REQ-019 A shared package lcd_pkg SHALL hold:
- the state enum;
- command constants CMD_FUNC_SET=0x28, CMD_DISP_ON=0x0C, CMD_ENTRY=0x06, CMD_CLEAR=0x01, CMD_LINE1=0x80, CMD_LINE2=0xC0;
- ASCII_SPACE=0x20.
REQ-020 The sub-module lcd_nibble_tx SHALL implement REQ-006, using start/busy/done handshake signals.

Verification
REQ-021 Bench parameters SHALL be POWERUP=20, E_HIGH=2, GAP=3, CMD_WAIT=4, CLEAR_WAIT=10.
REQ-022 Directed scenarios:
- Reset release -> first lcd_e rise 21 clocks later, with nibble 0x3 and rs=0.
- INIT decode -> nibble stream 3,3,3,2,2,8,0,C,0,6,0,1, all rs=0; a 10-clock gap follows the final 1.
- first_line_data="0, 1, 2, 3" padded with 0x00 -> rs=1 bytes 30 2C 20 31 2C 20 32 2C 20 33, then six 00 bytes, or six 20 bytes with LCD_NULL_AS_SPACE_EN.
- second_line_data changed mid-LINE1 -> current frame shows old line 2; next frame shows new line 2.
- rst pulsed during the LINE2 k=7 lcd_e high -> lcd_e=0 next cycle, init_done=0, full sequence replays.
- Two consecutive frames -> frame_done pulses exactly once per frame; each frame is 0x80, 16 bytes, 0xC0, 16 bytes.
